extend_arbiter: RTL and testbench

Shares one sign/zero-extension datapath between two requesters. Each requester presents a 16-bit operand and an extension mode over a valid/ready handshake. A round-robin arbiter grants one requester per cycle, and the extended 32-bit result is registered into a single output stage with its own valid/ready handshake. The block sits between operand producers (load path, immediate decode) and the 32-bit execute datapath.

---
 rtl/extend_arbiter_if.sv | 46 ++++
 rtl/extend_arbiter.sv | 114 +++++++++++
 tb/tb_extend_arbiter.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/extend_arbiter_if.sv
// extend_arbiter_if
// Purpose: bundles the two requester handshakes and the result handshake of
//          extend_arbiter.
// Ports (signals):
//   req0_valid/req0_ready/req0_data/req0_mode : requester 0 operand channel
//   req1_valid/req1_ready/req1_data/req1_mode : requester 1 operand channel
//   out_valid/out_ready/out_data/out_src      : registered result channel
//   xfer_count                                : completed result transfers mod 256
// Modports: master = producers/consumer side, slave = the arbiter itself.
// Handshake: a channel transfers on a cycle where valid && ready are both high
// at the rising clock edge; valid must not depend combinationally on ready,
// and data/mode must be stable whenever valid is high.
interface extend_arbiter_if #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
);
  logic              req0_valid;
  logic              req0_ready;
  logic [IN_W-1:0]   req0_data;
  logic [1:0]        req0_mode;
  logic              req1_valid;
  logic              req1_ready;
  logic [IN_W-1:0]   req1_data;
  logic [1:0]        req1_mode;
  logic              out_valid;
  logic              out_ready;
  logic [OUT_W-1:0]  out_data;
  logic              out_src;
  logic [7:0]        xfer_count;

  modport master (
    output req0_valid, req0_data, req0_mode,
    output req1_valid, req1_data, req1_mode,
    output out_ready,
    input  req0_ready, req1_ready,
    input  out_valid, out_data, out_src, xfer_count
  );

  modport slave (
    input  req0_valid, req0_data, req0_mode,
    input  req1_valid, req1_data, req1_mode,
    input  out_ready,
    output req0_ready, req1_ready,
    output out_valid, out_data, out_src, xfer_count
  );
endinterface

// File: rtl/extend_arbiter.sv
// extend_arbiter
// Purpose: round-robin shares one sign/zero-extension datapath between two
//          requesters and registers the 32-bit result in a single output stage.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : extend_arbiter_if.slave (requester channels, result channel,
//           transfer counter). out_valid doubles as the debug view of the
//           output FSM state (EMPTY=0, FULL=1).
// Modes: 00 sext half, 01 zext half, 10 sext byte, 11 zext byte.
module extend_arbiter (
  input  logic                clk,
  input  logic                rst_n,
  extend_arbiter_if.slave     bus
);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  state_t       r_state;
  logic [31:0]  r_out_data;
  logic         r_out_src;
  logic [7:0]   r_xfer_count;
  logic         r_last_grant;

  logic         w_out_valid;
  logic         w_can_accept;
  logic         w_grant0;
  logic         w_grant1;
  logic         w_acc0;
  logic         w_acc1;
  logic         w_accept;
  logic [15:0]  w_sel_data;
  logic [1:0]   w_sel_mode;
  logic [31:0]  w_ext;
  logic         w_drain;

  function automatic logic [31:0] f_extend(input logic [15:0] d, input logic [1:0] m);
    logic [31:0] res;
    case (m)
      2'b00:   res = {{16{d[15]}}, d};
      2'b01:   res = {16'h0000, d};
      2'b10:   res = {{24{d[7]}}, d[7:0]};
      default: res = {24'h000000, d[7:0]};
    endcase
    return res;
  endfunction

  assign w_out_valid  = (r_state == ST_FULL);
  // Full throughput: a draining result frees the stage in the same cycle.
  assign w_can_accept = !w_out_valid || bus.out_ready;

  // Ties go to whoever did not win last time; a lone requester always wins.
  assign w_grant0 = bus.req0_valid && (!bus.req1_valid || r_last_grant);
  assign w_grant1 = bus.req1_valid && (!bus.req0_valid || !r_last_grant);

  // rst_n gates the readies so nothing is accepted while reset is held.
  assign bus.req0_ready = rst_n && w_can_accept && w_grant0;
  assign bus.req1_ready = rst_n && w_can_accept && w_grant1;

  assign w_acc0   = bus.req0_valid && bus.req0_ready;
  assign w_acc1   = bus.req1_valid && bus.req1_ready;
  assign w_accept = w_acc0 || w_acc1;

  assign w_sel_data = w_acc1 ? bus.req1_data : bus.req0_data;
  assign w_sel_mode = w_acc1 ? bus.req1_mode : bus.req0_mode;
  assign w_ext      = f_extend(w_sel_data, w_sel_mode);

  assign w_drain = w_out_valid && bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_EMPTY;
      r_out_data   <= 32'h0;
      r_out_src    <= 1'b0;
      r_xfer_count <= 8'h00;
      r_last_grant <= 1'b1;
    end else begin
      if (w_drain) begin
        r_xfer_count <= r_xfer_count + 8'd1;
      end
      case (r_state)
        ST_EMPTY: begin
          if (w_accept) begin
            r_state      <= ST_FULL;
            r_out_data   <= w_ext;
            r_out_src    <= w_acc1;
            r_last_grant <= w_acc1;
          end
        end
        ST_FULL: begin
          if (w_accept) begin
            // Drain and refill in the same cycle: new result replaces old.
            r_state      <= ST_FULL;
            r_out_data   <= w_ext;
            r_out_src    <= w_acc1;
            r_last_grant <= w_acc1;
          end else if (bus.out_ready) begin
            r_state <= ST_EMPTY;
          end
        end
        default: r_state <= ST_EMPTY;
      endcase
    end
  end

  assign bus.out_valid  = w_out_valid;
  assign bus.out_data   = r_out_data;
  assign bus.out_src    = r_out_src;
  assign bus.xfer_count = r_xfer_count;

endmodule

// File: tb/tb_extend_arbiter.sv
module tb_extend_arbiter;

  logic clk;
  logic rst_n;

  extend_arbiter_if bus ();

  extend_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int n_tests;
  int n_fail;

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%08h exp=0x%08h t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Advance one clock; returns 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Short reset pulse placed between edges.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    #1;
  endtask

  task automatic drive(input logic v0, input logic [15:0] d0, input logic [1:0] m0,
                       input logic v1, input logic [15:0] d1, input logic [1:0] m1,
                       input logic ordy);
    bus.req0_valid = v0;
    bus.req0_data  = d0;
    bus.req0_mode  = m0;
    bus.req1_valid = v1;
    bus.req1_data  = d1;
    bus.req1_mode  = m1;
    bus.out_ready  = ordy;
  endtask

  // ---------------- directed vectors ----------------
  logic [15:0] mv_data [5];
  logic [1:0]  mv_mode [5];
  logic [31:0] mv_exp  [5];

  initial begin
    mv_data = '{16'h8000, 16'h8000, 16'hAAF0, 16'hAAF0, 16'h7FFF};
    mv_mode = '{2'b00,    2'b01,    2'b10,    2'b11,    2'b00};
    mv_exp  = '{32'hFFFF8000, 32'h00008000, 32'hFFFFFFF0, 32'h000000F0, 32'h00007FFF};
  end

  // ---------------- main sequence ----------------
  initial begin
    logic exp_src;
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    // Valids high during reset: readies must still be low.
    drive(1'b1, 16'h0001, 2'b01, 1'b1, 16'h0002, 2'b01, 1'b1);
    #12;
    check("rst_valid", 32'(bus.out_valid), 32'd0);
    check("rst_data",  bus.out_data, 32'h0);
    check("rst_src",   32'(bus.out_src), 32'd0);
    check("rst_xfer",  32'(bus.xfer_count), 32'd0);
    check("rst_rdy0",  32'(bus.req0_ready), 32'd0);
    check("rst_rdy1",  32'(bus.req1_ready), 32'd0);
    @(posedge clk);
    #1;
    check("rst_hold_valid", 32'(bus.out_valid), 32'd0);
    drive(1'b0, 16'h0, 2'b00, 1'b0, 16'h0, 2'b00, 1'b1);
    #2;
    rst_n = 1'b1;

    // ---- extension modes, requester 0 alone ----
    tick();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, mv_data[i], mv_mode[i], 1'b0, 16'h0, 2'b00, 1'b1);
      #1;
      check("mode_rdy0", 32'(bus.req0_ready), 32'd1);
      tick();
      bus.req0_valid = 1'b0;
      check("mode_valid", 32'(bus.out_valid), 32'd1);
      check("mode_data",  bus.out_data, mv_exp[i]);
      check("mode_src",   32'(bus.out_src), 32'd0);
    end

    // ---- contention: strict alternation starting at req0 ----
    do_reset();
    check("cont_pre_valid", 32'(bus.out_valid), 32'd0);
    drive(1'b1, 16'h0001, 2'b01, 1'b1, 16'h0002, 2'b01, 1'b1);
    for (int i = 0; i < 6; i++) begin
      exp_src = i[0];
      #1;
      check("cont_rdy0", 32'(bus.req0_ready), 32'(!exp_src));
      check("cont_rdy1", 32'(bus.req1_ready), 32'(exp_src));
      tick();
      check("cont_valid", 32'(bus.out_valid), 32'd1);
      check("cont_src",   32'(bus.out_src), 32'(exp_src));
      check("cont_data",  bus.out_data, exp_src ? 32'h2 : 32'h1);
    end
    check("cont_xfer", 32'(bus.xfer_count), 32'd5);

    // ---- backpressure: pending src=1 data=2, stall 3 cycles ----
    bus.out_ready = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      check("bp_rdy0", 32'(bus.req0_ready), 32'd0);
      check("bp_rdy1", 32'(bus.req1_ready), 32'd0);
      tick();
      check("bp_valid", 32'(bus.out_valid), 32'd1);
      check("bp_data",  bus.out_data, 32'h2);
      check("bp_src",   32'(bus.out_src), 32'd1);
    end
    check("bp_xfer", 32'(bus.xfer_count), 32'd5);
    bus.out_ready = 1'b1;
    #1;
    check("bp_rel_rdy0", 32'(bus.req0_ready), 32'd1);
    check("bp_rel_rdy1", 32'(bus.req1_ready), 32'd0);
    tick();
    check("bp_rel_src",  32'(bus.out_src), 32'd0);
    check("bp_rel_data", bus.out_data, 32'h1);
    check("bp_rel_xfer", 32'(bus.xfer_count), 32'd6);

    // ---- lone requester 1 for 4 cycles, then tie ----
    drive(1'b0, 16'h0001, 2'b01, 1'b1, 16'h0002, 2'b01, 1'b1);
    for (int i = 0; i < 4; i++) begin
      #1;
      check("lone_rdy1", 32'(bus.req1_ready), 32'd1);
      tick();
      check("lone_src", 32'(bus.out_src), 32'd1);
    end
    bus.req0_valid = 1'b1;
    #1;
    check("lone_tie_rdy0", 32'(bus.req0_ready), 32'd1);
    check("lone_tie_rdy1", 32'(bus.req1_ready), 32'd0);
    tick();
    check("lone_tie_src", 32'(bus.out_src), 32'd0);
    drive(1'b0, 16'h0, 2'b00, 1'b0, 16'h0, 2'b00, 1'b1);
    tick();
    check("drain_valid", 32'(bus.out_valid), 32'd0);
    check("drain_xfer",  32'(bus.xfer_count), 32'd12);
    check("drain_hold_data", bus.out_data, 32'h1);

    // ---- asynchronous reset with a stalled result ----
    drive(1'b1, 16'h1234, 2'b00, 1'b0, 16'h0, 2'b00, 1'b0);
    #1;
    check("ar_rdy0", 32'(bus.req0_ready), 32'd1);
    tick();
    bus.req0_valid = 1'b0;
    check("ar_pre_valid", 32'(bus.out_valid), 32'd1);
    check("ar_pre_data",  bus.out_data, 32'h00001234);
    check("ar_pre_xfer",  32'(bus.xfer_count), 32'd12);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_valid", 32'(bus.out_valid), 32'd0);
    check("ar_data",  bus.out_data, 32'h0);
    check("ar_xfer",  32'(bus.xfer_count), 32'd0);
    rst_n = 1'b1;
    drive(1'b1, 16'h0001, 2'b01, 1'b1, 16'h0002, 2'b01, 1'b1);
    #1;
    check("ar_tie_rdy0", 32'(bus.req0_ready), 32'd1);
    check("ar_tie_rdy1", 32'(bus.req1_ready), 32'd0);
    tick();
    check("ar_tie_src",  32'(bus.out_src), 32'd0);
    check("ar_tie_data", bus.out_data, 32'h1);

    // ---- counter wrap: edge i completes i-1 transfers ----
    do_reset();
    drive(1'b1, 16'h00FF, 2'b11, 1'b0, 16'h0, 2'b00, 1'b1);
    check("wrap_start", 32'(bus.xfer_count), 32'd0);
    for (int i = 1; i <= 258; i++) begin
      tick();
      if (i == 256) check("wrap_255", 32'(bus.xfer_count), 32'd255);
      if (i == 257) check("wrap_0",   32'(bus.xfer_count), 32'd0);
      if (i == 258) check("wrap_1",   32'(bus.xfer_count), 32'd1);
    end
    check("wrap_data", bus.out_data, 32'h000000FF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
